// File: rtl/spi_mnrch_param.sv
// Parametrised SPI monarch, mode 3, one DATA_W-bit word per transfer, NUM_SS selects.
// Optional SPI_MNRCH_LSB_FIRST_EN: shift LSB first (default build is MSB first).
`timescale 1ns/1ps
module spi_mnrch_param #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SCLK_DIV_W = 5,
  parameter int unsigned NUM_SS     = 1,
  parameter int unsigned SS_SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrt,
  input  logic [SS_SEL_W-1:0] ss_sel,
  input  logic [DATA_W-1:0]   wt_data,
  input  logic                MISO,
  output logic [NUM_SS-1:0]   SS_n,
  output logic                SCLK,
  output logic                MOSI,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [SCLK_DIV_W-1:0] DivLoad = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] SmplVal = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StFrontPorch, StTrans, StBackPorch} state_e;

  state_e                r_state;
  logic [SCLK_DIV_W-1:0] r_cnt;
  logic [DATA_W-1:0]     r_shft;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [NUM_SS-1:0]     r_ss_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_miso_smpl;

  logic                  w_smpl;
  logic                  w_shft_imm;
  logic [DATA_W-1:0]     w_shft_nxt;
  logic [NUM_SS-1:0]     w_ss_dec;

  assign w_smpl     = (r_cnt == SmplVal);
  assign w_shft_imm = &r_cnt;

`ifdef SPI_MNRCH_LSB_FIRST_EN
  assign w_shft_nxt = {r_miso_smpl, r_shft[DATA_W-1:1]};
  assign MOSI       = r_shft[0];
`else
  assign w_shft_nxt = {r_shft[DATA_W-2:0], r_miso_smpl};
  assign MOSI       = r_shft[DATA_W-1];
`endif

  // Out-of-range index leaves every select high (dummy transfer).
  always_comb begin
    w_ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_SEL_W'(i)) w_ss_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '1;
      r_shft      <= '0;
      r_bit_cnt   <= '0;
      r_ss_n      <= '1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_miso_smpl <= 1'b0;
    end else begin
      if (w_smpl) r_miso_smpl <= MISO;
      r_cnt <= r_cnt + 1'b1;
      unique case (r_state)
        StIdle: begin
          // Divider held at its load value so SCLK stays high while idle.
          r_cnt <= DivLoad;
          if (wrt) begin
            r_shft    <= wt_data;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_ss_n    <= w_ss_dec;
            r_state   <= StFrontPorch;
          end
        end
        StFrontPorch: begin
          if (w_shft_imm) r_state <= StTrans;
        end
        StTrans: begin
          if (w_shft_imm) begin
            r_shft    <= w_shft_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
            r_state <= StBackPorch;
          end
        end
        StBackPorch: begin
          if (w_shft_imm) begin
            r_shft  <= w_shft_nxt;
            r_cnt   <= DivLoad;
            r_done  <= 1'b1;
            r_ss_n  <= '1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign SS_n    = r_ss_n;
  assign SCLK    = r_cnt[SCLK_DIV_W-1];
  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_data = r_shft;

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Scoreboard bench: a 16-bit/4-select monarch and an 8-bit/1-select monarch, each with a
// mode-3 slave model; expected results are queued at issue and checked when done rises.
`timescale 1ns/1ps
module tb_spi_mnrch_param;
`ifdef SPI_MNRCH_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif
  localparam int LatM = 521;  // 8 + 1 + 16*32
  localparam int LatS = 67;   // 2 + 1 + 8*8

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          exp_edge;
    logic [15:0] exp_rd;
    logic [15:0] exp_tx;
    logic        exp_first;
    bit          chk_data;
  } exp_t;
  exp_t q_m[$];
  exp_t q_s[$];

  // Main DUT: DATA_W=16, SCLK_DIV_W=5, NUM_SS=4
  logic        wrt_m, miso_m = 1'b0, sclk_m, mosi_m, busy_m, done_m;
  logic [1:0]  sel_m;
  logic [15:0] wd_m, rd_m;
  logic [3:0]  ssn_m;

  spi_mnrch_param #(.DATA_W(16), .SCLK_DIV_W(5), .NUM_SS(4)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_m), .ss_sel(sel_m), .wt_data(wd_m), .MISO(miso_m),
    .SS_n(ssn_m), .SCLK(sclk_m), .MOSI(mosi_m), .busy(busy_m), .done(done_m), .rd_data(rd_m)
  );

  // Small DUT: DATA_W=8, SCLK_DIV_W=3, NUM_SS=1
  logic       wrt_s, miso_s = 1'b0, sclk_s, mosi_s, busy_s, done_s, sel_s;
  logic [7:0] wd_s, rd_s;
  logic [0:0] ssn_s;

  spi_mnrch_param #(.DATA_W(8), .SCLK_DIV_W(3), .NUM_SS(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_s), .ss_sel(sel_s), .wt_data(wd_s), .MISO(miso_s),
    .SS_n(ssn_s), .SCLK(sclk_s), .MOSI(mosi_s), .busy(busy_s), .done(done_s), .rd_data(rd_s)
  );

  // Mode-3 slave models: drive on SCLK fall, sample on SCLK rise.
  logic [15:0] sl_word_m, sl_sh_m, sl_rx_m;
  logic        sclk_mq = 1'b1, sel_mq = 1'b0, sl_first_m = 1'b0;
  int          sl_cnt_m = 0;
  always @(posedge clk) begin
    sclk_mq <= sclk_m;
    sel_mq  <= ~&ssn_m;
    if (~&ssn_m && !sel_mq) begin
      sl_sh_m  <= sl_word_m;
      sl_cnt_m <= 0;
    end else if (~&ssn_m && sclk_mq && !sclk_m) begin
      miso_m  <= LsbFirst ? sl_sh_m[0] : sl_sh_m[15];
      sl_sh_m <= LsbFirst ? (sl_sh_m >> 1) : (sl_sh_m << 1);
    end else if (~&ssn_m && !sclk_mq && sclk_m) begin
      sl_rx_m  <= LsbFirst ? {mosi_m, sl_rx_m[15:1]} : {sl_rx_m[14:0], mosi_m};
      if (sl_cnt_m == 0) sl_first_m <= mosi_m;
      sl_cnt_m <= sl_cnt_m + 1;
    end
  end

  logic [7:0] sl_word_s, sl_sh_s, sl_rx_s;
  logic       sclk_sq = 1'b1, sel_sq = 1'b0, sl_first_s = 1'b0;
  int         sl_cnt_s = 0;
  always @(posedge clk) begin
    sclk_sq <= sclk_s;
    sel_sq  <= ~ssn_s[0];
    if (~ssn_s[0] && !sel_sq) begin
      sl_sh_s  <= sl_word_s;
      sl_cnt_s <= 0;
    end else if (~ssn_s[0] && sclk_sq && !sclk_s) begin
      miso_s  <= LsbFirst ? sl_sh_s[0] : sl_sh_s[7];
      sl_sh_s <= LsbFirst ? (sl_sh_s >> 1) : (sl_sh_s << 1);
    end else if (~ssn_s[0] && !sclk_sq && sclk_s) begin
      sl_rx_s  <= LsbFirst ? {mosi_s, sl_rx_s[7:1]} : {sl_rx_s[6:0], mosi_s};
      if (sl_cnt_s == 0) sl_first_s <= mosi_s;
      sl_cnt_s <= sl_cnt_s + 1;
    end
  end

  // Monitors: compare on each rising done.
  logic done_mp = 1'b0;
  exp_t em;
  always @(negedge clk) begin
    done_mp <= done_m;
    if (done_m && !done_mp) begin
      if (q_m.size() == 0) begin
        check("main unexpected done, queue depth", q_m.size(), 1);
      end else begin
        em = q_m.pop_front();
        check("main done edge", edge_no, em.exp_edge);
        check("main ss_n after done", ssn_m, 4'hF);
        check("main busy after done", busy_m, 1'b0);
        check("main sclk after done", sclk_m, 1'b1);
        if (em.chk_data) begin
          check("main rd_data", rd_m, em.exp_rd);
          check("main mosi word", sl_rx_m, em.exp_tx);
          check("main first mosi bit", sl_first_m, em.exp_first);
        end
      end
    end
  end

  logic done_sp = 1'b0;
  exp_t es;
  always @(negedge clk) begin
    done_sp <= done_s;
    if (done_s && !done_sp) begin
      if (q_s.size() == 0) begin
        check("small unexpected done, queue depth", q_s.size(), 1);
      end else begin
        es = q_s.pop_front();
        check("small done edge", edge_no, es.exp_edge);
        check("small ss_n after done", ssn_s, 1'b1);
        check("small busy after done", busy_s, 1'b0);
        if (es.chk_data) begin
          check("small rd_data", rd_s, es.exp_rd);
          check("small mosi word", sl_rx_s, es.exp_tx);
          check("small first mosi bit", sl_first_s, es.exp_first);
        end
      end
    end
  end

  task automatic push_m(input logic [15:0] wd, input logic [15:0] slw, input bit chk);
    exp_t e;
    e.exp_edge  = edge_no + 1 + LatM;
    e.exp_rd    = slw;
    e.exp_tx    = wd;
    e.exp_first = LsbFirst ? wd[0] : wd[15];
    e.chk_data  = chk;
    q_m.push_back(e);
  endtask

  task automatic push_s(input logic [7:0] wd, input logic [7:0] slw, input bit chk);
    exp_t e;
    e.exp_edge  = edge_no + 1 + LatS;
    e.exp_rd    = {8'h00, slw};
    e.exp_tx    = {8'h00, wd};
    e.exp_first = LsbFirst ? wd[0] : wd[7];
    e.chk_data  = chk;
    q_s.push_back(e);
  endtask

  task automatic issue_m(input logic [15:0] wd, input logic [1:0] sel, input logic [15:0] slw,
                         input bit expect_done);
    @(negedge clk);
    wd_m = wd; sel_m = sel; sl_word_m = slw; wrt_m = 1'b1;
    if (expect_done) push_m(wd, slw, 1'b1);
    @(negedge clk);
    wrt_m = 1'b0;
  endtask

  task automatic issue_s(input logic [7:0] wd, input logic sel, input logic [7:0] slw,
                         input bit chk);
    @(negedge clk);
    wd_s = wd; sel_s = sel; sl_word_s = slw; wrt_s = 1'b1;
    push_s(wd, slw, chk);
    @(negedge clk);
    wrt_s = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && (q_m.size() != 0 || q_s.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check(name, q_m.size() + q_s.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wrt_m = 1'b0; sel_m = '0; wd_m = '0; sl_word_m = '0;
    wrt_s = 1'b0; sel_s = '0; wd_s = '0; sl_word_s = '0;
    repeat (3) @(negedge clk);
    check("reset ss_n", ssn_m, 4'hF);
    check("reset sclk", sclk_m, 1'b1);
    check("reset mosi", mosi_m, 1'b0);
    check("reset busy", busy_m, 1'b0);
    check("reset done", done_m, 1'b0);
    check("reset rd_data", rd_m, 16'h0000);
    check("reset small ss_n", ssn_s, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer on select 2
    issue_m(16'hA5C3, 2'd2, 16'h3C5A, 1'b1);
    repeat (5) @(negedge clk);
    check("select 2 ss_n", ssn_m, 4'b1011);
    check("busy during transfer", busy_m, 1'b1);
    drain("drain basic");

    // wrt pulses mid-transfer are ignored
    issue_m(16'h1234, 2'd0, 16'h0F0F, 1'b1);
    repeat (9) @(negedge clk);
    wrt_m = 1'b1; wd_m = 16'hFFFF; sel_m = 2'd1;
    @(negedge clk);
    wrt_m = 1'b0;
    repeat (289) @(negedge clk);
    wrt_m = 1'b1;
    @(negedge clk);
    wrt_m = 1'b0;
    check("ignored wrt ss_n", ssn_m, 4'b1110);
    drain("drain ignored wrt");
    repeat (600) @(negedge clk);
    check("no extra done after ignored wrt", q_m.size(), 0);

    // First-bit ordering
    issue_m(16'h0001, 2'd1, 16'h8001, 1'b1);
    drain("drain first bit");

    // Reset 200 edges into a transfer
    issue_m(16'hBEEF, 2'd3, 16'h1111, 1'b0);
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset ss_n", ssn_m, 4'hF);
    check("mid reset sclk", sclk_m, 1'b1);
    check("mid reset busy", busy_m, 1'b0);
    check("mid reset done", done_m, 1'b0);
    repeat (400) @(negedge clk);
    check("no done after abandoned transfer", done_m, 1'b0);
    issue_m(16'h5AA5, 2'd3, 16'hC33C, 1'b1);
    drain("drain after reset");

    // Small DUT, then back-to-back with wrt on the first idle cycle
    issue_s(8'h96, 1'b0, 8'h3C, 1'b1);
    for (int i = 0; i < 200 && !done_s; i++) @(negedge clk);
    check("small done seen", done_s, 1'b1);
    wd_s = 8'h81; sel_s = 1'b0; sl_word_s = 8'h7E; wrt_s = 1'b1;
    push_s(8'h81, 8'h7E, 1'b1);
    @(negedge clk);
    wrt_s = 1'b0;
    check("back-to-back done cleared", done_s, 1'b0);
    check("back-to-back busy", busy_s, 1'b1);
    drain("drain back-to-back");

    // Out-of-range select: dummy transfer, selects never drop
    issue_s(8'hA5, 1'b1, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("dummy ss_n", ssn_s, 1'b1);
    check("dummy busy", busy_s, 1'b1);
    drain("drain dummy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
